// File: rtl/mem_arbiter_rr.sv
// Shared-memory arbiter: multiplexes CORE_NUM core ports onto one single-ported
// data memory with round-robin or fixed-priority grants and a programmable read latency.
module mem_arbiter_rr #(
    parameter int WIDTH         = 32,
    parameter int CORE_NUM      = 4,
    parameter int RD_LATENCY    = 1,
    parameter int PRIORITY_MODE = 0,
    localparam int IDX_W        = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CORE_NUM-1:0]       request,
    input  logic [CORE_NUM-1:0]       wren_core,
    input  logic [CORE_NUM*WIDTH-1:0] address_in_core,
    input  logic [CORE_NUM*WIDTH-1:0] data_in_core,
    output logic [CORE_NUM*WIDTH-1:0] data_out_core,
    output logic [CORE_NUM-1:0]       response,
    output logic [WIDTH-1:0]          address,
    output logic [WIDTH-1:0]          data_write,
    output logic                      wren,
    input  logic [WIDTH-1:0]          data_read,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic             is_write;
    logic [3:0]       wait_cnt;
    int               idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|request) state_next = ISSUE;
            ISSUE:   state_next = is_write ? RESP : WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Round-robin search starts one past the last grant; fixed priority always starts at core 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            if (PRIORITY_MODE != 0) begin
                idx = k;
            end else begin
                idx = (int'(last_grant) + 1 + k) % CORE_NUM;
            end
            sel = IDX_W'(idx);
            if (!found && request[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= IDX_W'(CORE_NUM - 1);
            grant_idx     <= '0;
            address       <= '0;
            data_write    <= '0;
            wren          <= 1'b0;
            is_write      <= 1'b0;
            wait_cnt      <= '0;
            response      <= '0;
            data_out_core <= '0;
        end else begin
            wren     <= 1'b0;
            response <= '0;
            case (state)
                IDLE: begin
                    if (|request) begin
                        grant_idx  <= winner;
                        last_grant <= winner;
                        address    <= address_in_core[int'(winner)*WIDTH +: WIDTH];
                        data_write <= data_in_core[int'(winner)*WIDTH +: WIDTH];
                        wren       <= wren_core[winner];
                        is_write   <= wren_core[winner];
                    end
                end
                ISSUE: begin
                    if (is_write) begin
                        response[grant_idx] <= 1'b1;
                    end else begin
                        wait_cnt <= 4'(RD_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        data_out_core[int'(grant_idx)*WIDTH +: WIDTH] <= data_read;
                        response[grant_idx] <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin instance (read latency 3) and a fixed-priority
// instance (read latency 2), each backed by its own behavioural memory.
module tb_mem_arbiter_rr;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req [2];
    logic [N-1:0]   wrc [2];
    logic [N-1:0]   resp [2];
    logic [N*W-1:0] ain [2];
    logic [N*W-1:0] din [2];
    logic [N*W-1:0] dout [2];
    logic [W-1:0]   addr_o [2];
    logic [W-1:0]   dwr_o [2];
    logic [W-1:0]   drd [2];
    logic           wren_o [2];
    logic           busy_o [2];
    logic [1:0]     gidx [2];

    logic [W-1:0]   mem_env [2][256];
    bit             mem_valid [2][256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Untouched locations read back a fixed address-derived pattern.
    function automatic logic [31:0] mem_init(input int a);
        return 32'(a) * 32'h123 + 32'h4;
    endfunction

    always_comb begin
        drd[0] = mem_valid[0][addr_o[0][7:0]] ? mem_env[0][addr_o[0][7:0]] : mem_init(int'(addr_o[0][7:0]));
        drd[1] = mem_valid[1][addr_o[1][7:0]] ? mem_env[1][addr_o[1][7:0]] : mem_init(int'(addr_o[1][7:0]));
    end

    always @(posedge clk) begin
        if (wren_o[0]) begin
            mem_env[0][addr_o[0][7:0]]   <= dwr_o[0];
            mem_valid[0][addr_o[0][7:0]] <= 1'b1;
        end
        if (wren_o[1]) begin
            mem_env[1][addr_o[1][7:0]]   <= dwr_o[1];
            mem_valid[1][addr_o[1][7:0]] <= 1'b1;
        end
    end

    mem_arbiter_rr #(.WIDTH(W), .CORE_NUM(N), .RD_LATENCY(3), .PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .request(req[0]), .wren_core(wrc[0]),
        .address_in_core(ain[0]), .data_in_core(din[0]), .data_out_core(dout[0]),
        .response(resp[0]), .address(addr_o[0]), .data_write(dwr_o[0]), .wren(wren_o[0]),
        .data_read(drd[0]), .grant_idx(gidx[0]), .busy(busy_o[0])
    );

    mem_arbiter_rr #(.WIDTH(W), .CORE_NUM(N), .RD_LATENCY(2), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .request(req[1]), .wren_core(wrc[1]),
        .address_in_core(ain[1]), .data_in_core(din[1]), .data_out_core(dout[1]),
        .response(resp[1]), .address(addr_o[1]), .data_write(dwr_o[1]), .wren(wren_o[1]),
        .data_read(drd[1]), .grant_idx(gidx[1]), .busy(busy_o[1])
    );

    task automatic set_core(input int d, input int i, input bit wr, input logic [31:0] a, input logic [31:0] dt);
        wrc[d][i]       = wr;
        ain[d][i*W +: W] = a;
        din[d][i*W +: W] = dt;
        req[d][i]       = 1'b1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req[0] = '0;
        req[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy_o[d], wren_o[d], resp[d], gidx[d]} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_ctrl[%0d]: got %b, expected 0", d, {busy_o[d], wren_o[d], resp[d], gidx[d]});
            end
            checks++;
            if ({addr_o[d], dwr_o[d], dout[d]} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_data[%0d]: got %h, expected 0", d, {addr_o[d], dwr_o[d], dout[d]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        @(negedge clk);
        set_core(0, 2, 1'b1, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({wren_o[0], busy_o[0], resp[0], gidx[0]} !== {1'b1, 1'b1, 4'b0000, 2'd2}) begin
            errors++;
            $display("[TB] FAIL write_issue_ctrl: got %b, expected %b", {wren_o[0], busy_o[0], resp[0], gidx[0]}, {1'b1, 1'b1, 4'b0000, 2'd2});
        end
        checks++;
        if ({addr_o[0], dwr_o[0]} !== {32'h40, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL write_issue_data: got %h, expected %h", {addr_o[0], dwr_o[0]}, {32'h40, 32'hDEADBEEF});
        end
        @(negedge clk);
        checks++;
        if ({resp[0], wren_o[0]} !== {4'b0100, 1'b0}) begin
            errors++;
            $display("[TB] FAIL write_response: got %b, expected %b", {resp[0], wren_o[0]}, {4'b0100, 1'b0});
        end
        req[0][2] = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o[0], resp[0]} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL write_idle: got %b, expected 0", {busy_o[0], resp[0]});
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        set_core(0, 1, 1'b0, 32'h10, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (wren_o[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL read_wren_c%0d: got %b, expected 0", c, wren_o[0]);
            end
            checks++;
            if (resp[0] !== ((c == 5) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL read_response_c%0d: got %b, expected %b", c, resp[0], (c == 5) ? 4'b0010 : 4'b0000);
            end
        end
        checks++;
        if (dout[0][1*W +: W] !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL read_data: got %h, expected %h", dout[0][1*W +: W], 32'h1234);
        end
        req[0][1] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_idle: got %b, expected 0", busy_o[0]);
        end
    endtask

    task automatic test_round_robin();
        int got = 0;
        do_reset();
        for (int i = 0; i < N; i++) set_core(0, i, 1'b1, 32'h40 + 32'(i), $urandom());
        for (int c = 0; c < 100 && got < 12; c++) begin
            @(negedge clk);
            if (resp[0] != '0) begin
                checks++;
                if (resp[0] !== (N'(1) << (got % N))) begin
                    errors++;
                    $display("[TB] FAIL rr_order_%0d: got %b, expected %b", got, resp[0], N'(1) << (got % N));
                end
                got++;
                if (got == 12) req[0] = '0;
            end
        end
        checks++;
        if (got != 12) begin
            errors++;
            $display("[TB] FAIL rr_count: got %0d, expected 12", got);
        end
        req[0] = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        int n1 = 0;
        int n3 = 0;
        @(negedge clk);
        set_core(1, 1, 1'b1, 32'h50, 32'h1111);
        set_core(1, 3, 1'b1, 32'h54, 32'h3333);
        for (int c = 0; c < 60 && n3 < 1; c++) begin
            @(negedge clk);
            if (resp[1] != '0) begin
                checks++;
                if (resp[1] !== ((n1 < 4) ? 4'b0010 : 4'b1000)) begin
                    errors++;
                    $display("[TB] FAIL fp_grant_%0d: got %b, expected %b", n1 + n3, resp[1], (n1 < 4) ? 4'b0010 : 4'b1000);
                end
                if (n1 < 4) n1++;
                else n3++;
                if (n1 == 4) req[1][1] = 1'b0;
            end
        end
        checks++;
        if (n1 + n3 != 5) begin
            errors++;
            $display("[TB] FAIL fp_count: got %0d, expected 5", n1 + n3);
        end
        req[1] = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_disturbance();
        @(negedge clk);
        set_core(0, 0, 1'b0, 32'h05, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2) req[0][0] = 1'b0;
            checks++;
            if (resp[0] !== ((c == 5) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL dist_response_c%0d: got %b, expected %b", c, resp[0], (c == 5) ? 4'b0001 : 4'b0000);
            end
        end
        checks++;
        if (dout[0][0 +: W] !== 32'h5B3) begin
            errors++;
            $display("[TB] FAIL dist_data: got %h, expected %h", dout[0][0 +: W], 32'h5B3);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_core(0, 3, 1'b1, 32'h48, 32'hCAFEF00D);
        @(negedge clk);
        checks++;
        if (wren_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rmid_wren_before: got %b, expected 1", wren_o[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wren_o[0], busy_o[0], resp[0], gidx[0]} !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_ctrl: got %b, expected 0", {wren_o[0], busy_o[0], resp[0], gidx[0]});
        end
        checks++;
        if ({addr_o[0], dwr_o[0], dout[0]} !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_data: got %h, expected 0", {addr_o[0], dwr_o[0], dout[0]});
        end
        req[0] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_core(0, 3, 1'b1, 32'h48, 32'h33);
        set_core(0, 1, 1'b1, 32'h4C, 32'h11);
        @(negedge clk);
        checks++;
        if ({gidx[0], wren_o[0], addr_o[0]} !== {2'd1, 1'b1, 32'h4C}) begin
            errors++;
            $display("[TB] FAIL rmid_first_grant: got %h, expected %h", {gidx[0], wren_o[0], addr_o[0]}, {2'd1, 1'b1, 32'h4C});
        end
        @(negedge clk);
        req[0] = '0;
        repeat (3) @(negedge clk);
    endtask

    // Transaction-level model: a grant is taken from the request vector seen while idle,
    // and the response lands 2 cycles later for a write or 2+latency cycles later for a read.
    task automatic test_random(input int d, input int lat, input bit prio, input int ncyc);
        int          issue_c = -10;
        int          resp_c  = -10;
        int          w       = 0;
        int          last    = N - 1;
        int          idx;
        bit          wr      = 1'b0;
        bit          have_txn = 1'b0;
        logic [31:0] a   = '0;
        logic [31:0] dat = '0;
        logic [31:0] exp_out [N];
        logic [31:0] emem [32];
        bit          pending [N];
        logic [N-1:0]   exp_resp;
        logic [N*W-1:0] exp_pack;
        bit          exp_wren;
        bit          exp_busy;
        for (int i = 0; i < N; i++) begin
            exp_out[i] = '0;
            pending[i] = 1'b0;
        end
        for (int i = 0; i < 32; i++) emem[i] = mem_init(i);
        do_reset();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (cyc == resp_c && !wr) exp_out[w] = emem[a[4:0]];
            exp_resp = (cyc == resp_c) ? (N'(1) << w) : '0;
            exp_wren = (cyc == issue_c) && wr;
            exp_busy = (cyc >= issue_c) && (cyc <= resp_c);
            for (int i = 0; i < N; i++) exp_pack[i*W +: W] = exp_out[i];
            checks++;
            if ({resp[d], wren_o[d], busy_o[d]} !== {exp_resp, exp_wren, exp_busy}) begin
                errors++;
                $display("[TB] FAIL rand%0d_ctrl@%0d: got %b, expected %b", d, cyc, {resp[d], wren_o[d], busy_o[d]}, {exp_resp, exp_wren, exp_busy});
            end
            checks++;
            if (dout[d] !== exp_pack) begin
                errors++;
                $display("[TB] FAIL rand%0d_data_out@%0d: got %h, expected %h", d, cyc, dout[d], exp_pack);
            end
            if (have_txn) begin
                checks++;
                if ({gidx[d], addr_o[d], dwr_o[d]} !== {2'(w), a, dat}) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_mem_port@%0d: got %h, expected %h", d, cyc, {gidx[d], addr_o[d], dwr_o[d]}, {2'(w), a, dat});
                end
            end
            if (cyc == resp_c) begin
                pending[w] = 1'b0;
                if ($urandom_range(0, 3) != 0) begin
                    pending[w] = 1'b1;
                    set_core(d, w, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom());
                end else begin
                    req[d][w] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    set_core(d, i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom());
                end
            end
            if (cyc > issue_c && cyc < resp_c && req[d][w] && $urandom_range(0, 7) == 0) req[d][w] = 1'b0;
            if (cyc > resp_c && req[d] != '0) begin
                idx = -1;
                for (int k = 0; k < N; k++) begin
                    int cand;
                    cand = prio ? k : (last + 1 + k) % N;
                    if (idx < 0 && req[d][cand]) idx = cand;
                end
                w        = idx;
                last     = idx;
                wr       = wrc[d][w];
                a        = ain[d][w*W +: W];
                dat      = din[d][w*W +: W];
                issue_c  = cyc + 1;
                resp_c   = wr ? cyc + 2 : cyc + 2 + lat;
                have_txn = 1'b1;
                if (wr) emem[a[4:0]] = dat;
            end
        end
        req[d] = '0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = '0;
            wrc[d] = '0;
            ain[d] = '0;
            din[d] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_fixed_priority();
        test_disturbance();
        test_reset_mid();
        test_random(0, 3, 1'b0, 400);
        test_random(1, 2, 1'b1, 400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
